// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter with one-shot/periodic modes, tc pulse and sticky expired flag.
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             enable,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             expired
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] out_n, reload_reg, reload_n;
  logic tc_n, expired_n, mode_reg, mode_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out <= '0;
      tc <= 1'b0;
      expired <= 1'b0;
      reload_reg <= '0;
      mode_reg <= 1'b0;
    end else begin
      state <= state_n;
      out <= out_n;
      tc <= tc_n;
      expired <= expired_n;
      reload_reg <= reload_n;
      mode_reg <= mode_n;
    end
  end
  // in RUN, out is never 0, so reaching 1 is the terminal step
  always_comb begin
    state_n = state;
    out_n = out;
    tc_n = 1'b0;
    expired_n = expired & ~clear;
    reload_n = reload_reg;
    mode_n = mode_reg;
    if (load) begin
      reload_n = load_value;
      out_n = load_value;
      mode_n = mode;
      expired_n = 1'b0;
      state_n = |load_value ? RUN : IDLE;
    end else if (state == RUN && stop) begin
      state_n = IDLE;
    end else if (state == RUN && enable) begin
      if (out > 1) begin
        out_n = out - 1'b1;
      end else begin
        tc_n = 1'b1;
        expired_n = 1'b1;
        out_n = mode_reg ? reload_reg : '0;
        state_n = mode_reg ? RUN : DONE;
      end
    end
  end
  assign busy = (state == RUN);
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed self-checking bench for down_counter_timer.
module tb_down_counter_timer;
  logic clk = 0, reset = 1, load = 0, mode = 0, enable = 0, stop = 0, clear = 0;
  logic [7:0] load_value = 0;
  logic [7:0] out;
  logic busy, tc, expired;
  int checks = 0, fails = 0;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .mode(mode),
    .enable(enable), .stop(stop), .clear(clear), .out(out), .busy(busy), .tc(tc),
    .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] o, input logic b, input logic t, input logic e);
    check({tag, ".out"}, out, o);
    check({tag, ".busy"}, busy, b);
    check({tag, ".tc"}, tc, t);
    check({tag, ".expired"}, expired, e);
  endtask

  task automatic do_load(input logic [7:0] v, input logic m);
    load = 1; load_value = v; mode = m;
    tick;
    load = 0;
  endtask

  initial begin
    int n, tcs;
    logic [7:0] eo;
    tick; tick;
    reset = 0; enable = 1;
    for (int i = 0; i < 3; i++) begin tick; check_all("reset_idle", 0, 0, 0, 0); end

    do_load(5, 0);
    check_all("os_load", 5, 1, 0, 0);
    for (int i = 4; i >= 0; i--) begin
      tick;
      check_all("os_run", i[7:0], i != 0, i == 0, i == 0);
    end
    for (int i = 0; i < 10; i++) begin tick; check_all("os_hold", 0, 0, 0, 1); end

    do_load(3, 1);
    check_all("per_load", 3, 1, 0, 0);
    eo = 3; tcs = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      eo = (eo == 1) ? 8'd3 : eo - 8'd1;
      if (tc) tcs++;
      check("per_out", out, eo);
      check("per_tc", tc, (i % 3) == 2);
    end
    check("per_tc_count", tcs, 4);
    clear = 1;
    tick; check_all("per_clear", 2, 1, 0, 0);
    tick; check_all("per_clear2", 1, 1, 0, 0);
    tick; check_all("per_clear_tc", 3, 1, 1, 1);
    clear = 0;

    load = 1; load_value = 4; mode = 0; enable = 1;
    tick; load = 0;
    check_all("gate_load", 4, 1, 0, 0);
    enable = 1; tick; check("gate_e1", out, 3);
    enable = 0; tick; check("gate_e0", out, 3);
    enable = 1; tick; check("gate_e1b", out, 2);
    enable = 0; tick; check("gate_e0b", out, 2);
    stop = 1; enable = 1;
    tick; check_all("stop", 2, 0, 0, 0);
    stop = 0;
    for (int i = 0; i < 4; i++) begin tick; check_all("stop_hold", 2, 0, 0, 0); end

    do_load(255, 0);
    n = 0;
    while (!tc && n < 300) begin tick; n++; end
    check("max_cycles", n, 255);
    check_all("max_end", 0, 0, 1, 1);

    do_load(0, 0);
    check_all("zero_load", 0, 0, 0, 0);
    tick; check_all("zero_hold", 0, 0, 0, 0);

    do_load(2, 1);
    tick; check("mid_pre", out, 1);
    tick; check_all("mid_tc", 2, 1, 1, 1);
    do_load(7, 0);
    check_all("mid_load", 7, 1, 0, 0);

    do_load(3, 0);
    tick; tick;
    check_all("rst_pre", 1, 1, 0, 0);
    reset = 1;
    tick; check_all("rst_mid", 0, 0, 0, 0);
    reset = 0;
    tick; check_all("rst_after", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down counter with terminal-count detection, forming the countdown half of the counter family. It loads a start value, decrements once per enabled cycle, and reports expiry with a one-cycle `tc` pulse and a sticky `expired` flag. It runs in one-shot mode (stops at zero) or periodic mode (auto-reloads). It sits beside the up counters as the timeout/interval source for control FSMs.

## Interface

- `WIDTH`, 8, counter and load-value width in bits
- `clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `load`  in  1  load request; captures `load_value` and `mode`
- `load_value`  in  WIDTH  start/reload value, sampled when `load`=1
- `mode`  in  1  0 = one-shot, 1 = periodic; sampled only when `load`=1
- `enable`  in  1  count qualifier; decrement happens only when high in RUN
- `stop`  in  1  abort: return to IDLE, hold `out`
- `clear`  in  1  clears `expired`
- `out`  out  WIDTH  current count, registered
- `busy`  out  1  high while in RUN, registered
- `tc`  out  1  terminal-count pulse, one cycle wide, registered
- `expired`  out  1  sticky, set by any `tc`

## Operation

- Internal state: `reload_reg` (WIDTH), `mode_reg` (1), and FSM {IDLE, RUN, DONE}.
- Priority per edge: reset > load > stop > decrement. `clear` is independent and applies only to `expired`.
- Reset: `out`=0, `busy`=0, `tc`=0, `expired`=0, `reload_reg`=0, `mode_reg`=0, state IDLE.
- Load, from any state:
  - `reload_reg`<=`load_value`, `out`<=`load_value`, `mode_reg`<=`mode`, `expired`<=0.
  - If `load_value`!=0, go to RUN. If `load_value`=0, go to IDLE with `out`=0 and no `tc`.
- Stop (no load): go to IDLE, `out` holds, `tc`=0. Stop in IDLE or DONE has no effect.
- RUN with `enable`=1:
  - If `out`>1: `out`<=`out`-1.
  - If `out`=1 and `mode_reg`=0 (one-shot): `out`<=0, `tc`<=1, `expired`<=1, go to DONE.
  - If `out`=1 and `mode_reg`=1 (periodic): `out`<=`reload_reg`, `tc`<=1, `expired`<=1, stay in RUN. `out` never shows 0 in periodic mode.
- RUN with `enable`=0: all state holds and `tc`=0.
- IDLE and DONE: `enable` is ignored and `out` holds. A new `load` is the only way to restart.
- `tc` is 0 in every cycle not listed above.
- `expired`: set by `tc`, cleared by `clear` or `load`. If `clear` and `tc` occur in the same cycle, set wins.
- Arithmetic is unsigned, WIDTH bits. `out` never underflows; decrement is never applied at 0.
- `mode` and `load_value` changes while not loading have no effect on a run in progress.

## Timing

- All outputs are registered and change only on rising `clk`.
- `load` sampled at edge k: after edge k, `out`=`load_value` and `busy`=1 (if nonzero).
- `load` and `enable` both high at the same edge: load only, no decrement in that cycle.
- One-shot, value N, `enable` held high from edge k+1: `out` reaches 0 after edge k+N. `tc`=1 and `expired`=1 in the cycle after edge k+N. `busy`=0 from edge k+N.
- Periodic, value N, `enable` continuously high: `tc` pulses every N cycles. Value 1 gives `tc`=1 every cycle with `out` constant at 1.
- Gaps in `enable` stretch the count one-for-one; the count reached is measured in enabled cycles.
- Reset asserted mid-run: all outputs return to their reset values after that edge, and a pending `tc` is suppressed.
- Maximum one-shot count is 2^WIDTH−1 enabled cycles.

## Test plan

- **Reset:** reset for 2 cycles, then idle with `enable`=1 -> `out`=0, `busy`=0, `tc`=0, `expired`=0 throughout; no count.
- **One-shot:** load 5 with mode 0, `enable`=1 -> `out` reads 5,4,3,2,1,0. `tc` is high for exactly 1 cycle, coincident with the first `out`=0. `busy` falls with it, `expired` stays 1. `out` holds 0 for 10 more cycles.
- **Periodic:** load 3 with mode 1, `enable`=1 for 12 cycles -> `out` reads 3,2,1,3,2,1,… and `tc` pulses 4 times, 3 cycles apart. Then `clear`=1 -> `expired`=0 unless a `tc` lands on the same edge, in which case `expired` stays 1.
- **Enable gating and stop:** load 4, toggle `enable` 1,0,1,0 -> `out` goes 4,3,3,2,2. Then `stop` -> `busy`=0, `out` holds 2, no `tc` follows.
- **Boundaries:** with WIDTH=8, load 255 -> `tc` after exactly 255 enabled cycles. Load 0 -> `busy`=0, no `tc`. `load` mid-run with value 7 -> `out`=7 next cycle and `expired` cleared. Reset asserted the cycle before `tc` is due -> `tc` never asserts.
